// File: rtl/dds_pkg.sv
// Definitions shared by the DDS modulator and demodulator: modulation mode
// codes and the demodulator FSM state type.
package dds_pkg;

  localparam logic [3:0] MODE_ASK  = 4'b1000;
  localparam logic [3:0] MODE_BPSK = 4'b1010;
  localparam logic [3:0] MODE_QPSK = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    INTEG
  } demod_state_t;

  function automatic logic mode_supported(input logic [3:0] mode);
    return (mode == MODE_ASK) || (mode == MODE_BPSK) || (mode == MODE_QPSK);
  endfunction

endpackage

// File: rtl/iq_integrator.sv
// One correlator channel: registers sample*ref, then on the following edge
// loads or accumulates that product into a sign-extended ACC_W-bit integrator.
module iq_integrator #(
  parameter int ACC_W = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mul_en_i,
  input  logic signed [11:0]      sample_i,
  input  logic signed [11:0]      ref_i,
  input  logic                    load_i,
  input  logic                    accumulate_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [23:0]      prod_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod_ext = {{(ACC_W-24){prod_q[23]}}, prod_q};

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = prod_ext;
    end else if (accumulate_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (mul_en_i) begin
        prod_q <= 24'(sample_i) * 24'(ref_i);
      end
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dds_demod.sv
// Coherent integrate-and-dump demodulator: correlates samples against the local
// carrier and decides one ASK/BPSK/QPSK symbol per SYMBOL_LEN accepted samples.
module dds_demod
  import dds_pkg::*;
#(
  parameter int                      SYMBOL_LEN = 64,
  parameter int                      ACC_W      = 24 + $clog2(SYMBOL_LEN) + 1,
  parameter logic signed [ACC_W-1:0] ASK_THRESH = ACC_W'(longint'(SYMBOL_LEN) << 20)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         mode,
  input  logic signed [11:0] sample,
  input  logic               sample_valid,
  input  logic signed [11:0] ref_sin,
  input  logic signed [11:0] ref_cos,
  input  logic               sym_start,
  output logic [1:0]         data,
  output logic               data_valid,
  output logic signed [11:0] soft_i,
  output logic signed [11:0] soft_q
);

  localparam int               CNT_W    = $clog2(SYMBOL_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_LEN - 1);

  demod_state_t            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              mode_q, dec_mode_q;
  logic                    vld1_q, first1_q, last1_q, dec_q;
  logic                    accept, sym_hit, sym_begin, sym_abort, take, take_last;
  logic signed [ACC_W-1:0] i_acc, q_acc;
  logic [1:0]              data_d, data_q;
  logic                    data_valid_q;
  logic signed [11:0]      soft_i_q, soft_q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mode_supported(mode)) state_d = ACQ;
      ACQ: begin
        if (sym_begin)      state_d = INTEG;
        else if (sym_abort) state_d = IDLE;
      end
      INTEG:   if (sym_abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
    end
  end

  // A symbol starts on an explicit sym_start or on the sample after a wrap; an
  // unsupported mode at that moment drops back to IDLE instead.
  always_comb begin
    accept    = en && sample_valid && (state_q != IDLE);
    sym_hit   = accept && (sym_start || (state_q == INTEG && cnt_q == '0));
    sym_begin = sym_hit && mode_supported(mode);
    sym_abort = sym_hit && !mode_supported(mode);
    take      = sym_begin || (accept && state_q == INTEG && !sym_hit);
    take_last = take && !sym_begin && (cnt_q == LAST_CNT);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!en || sym_abort) begin
      cnt_d = '0;
    end else if (sym_begin) begin
      cnt_d = CNT_W'(1);
    end else if (take) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      mode_q     <= '0;
      vld1_q     <= 1'b0;
      first1_q   <= 1'b0;
      last1_q    <= 1'b0;
      dec_q      <= 1'b0;
      dec_mode_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      vld1_q   <= take;
      first1_q <= sym_begin;
      last1_q  <= take_last;
      dec_q    <= vld1_q && last1_q;
      if (sym_begin) begin
        mode_q <= mode;
      end
      if (vld1_q && last1_q) begin
        dec_mode_q <= mode_q;
      end
    end
  end

  iq_integrator #(.ACC_W(ACC_W)) u_int_i (
    .clk          (clk),
    .rst_n        (rst),
    .mul_en_i     (take),
    .sample_i     (sample),
    .ref_i        (ref_sin),
    .load_i       (vld1_q && first1_q),
    .accumulate_i (vld1_q && !first1_q),
    .acc_o        (i_acc)
  );

  iq_integrator #(.ACC_W(ACC_W)) u_int_q (
    .clk          (clk),
    .rst_n        (rst),
    .mul_en_i     (take),
    .sample_i     (sample),
    .ref_i        (ref_cos),
    .load_i       (vld1_q && first1_q),
    .accumulate_i (vld1_q && !first1_q),
    .acc_o        (q_acc)
  );

  // The decision reads the accumulators before a back-to-back reload lands.
  always_comb begin
    data_d = '0;
    case (dec_mode_q)
      MODE_BPSK: data_d = {1'b0, i_acc[ACC_W-1]};
      MODE_ASK:  data_d = {1'b0, i_acc > ASK_THRESH};
      MODE_QPSK: data_d = {i_acc[ACC_W-1], q_acc[ACC_W-1]};
      default:   data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid_q <= 1'b0;
      data_q       <= '0;
      soft_i_q     <= '0;
      soft_q_q     <= '0;
    end else begin
      data_valid_q <= dec_q;
      if (dec_q) begin
        data_q   <= data_d;
        soft_i_q <= i_acc[ACC_W-1 -: 12];
        soft_q_q <= q_acc[ACC_W-1 -: 12];
      end
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign soft_i     = soft_i_q;
  assign soft_q     = soft_q_q;

endmodule
